// File: rtl/output_signature_compactor_pkg.sv
// Shared types and constants for the output signature compactor; FRAME_LEN depends on SIG_PARITY_EN.
// Pure definitions: no latency, no flow control.
package sig_compactor_pkg;

  localparam int SIG_WIDTH = 32;
  localparam logic [SIG_WIDTH-1:0] SIG_SEED = 32'h0;
  localparam logic [SIG_WIDTH-1:0] SIG_TAPS = 32'h8020_0003;
  localparam int MAX_BUS = 256;

`ifdef SIG_PARITY_EN
  localparam int FRAME_LEN = SIG_WIDTH + 1;
`else
  localparam int FRAME_LEN = SIG_WIDTH;
`endif

  typedef enum logic {IDLE, SHIFT} sig_state_t;

  // Callers zero-extend the bus, so unused top chunks fold in as zero.
  function automatic logic [SIG_WIDTH-1:0] fold_bus(input logic [MAX_BUS-1:0] bus);
    logic [SIG_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_BUS / SIG_WIDTH; i++) begin
      acc ^= bus[i*SIG_WIDTH +: SIG_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/output_signature_compactor_if.sv
// Bus between the DUT outputs and the compactor, plus the serial signature pins.
// Plain wires: no latency; the compactor never backpressures (data_valid only qualifies).
interface output_signature_compactor_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  sig_out;
  logic                  sig_frame;
  logic                  sig_done;

  modport master (output data_in, data_valid, input sig_out, sig_frame, sig_done);
  modport slave  (input data_in, data_valid, output sig_out, sig_frame, sig_done);
endinterface

// File: rtl/output_signature_compactor_misr_core.sv
// Folds the bus into a 32-bit MISR over WINDOW valid samples; flags completion combinationally.
// One-cycle update per valid sample; holds while data_valid is low, never stalls the source.
module misr_core
  import sig_compactor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic [SIG_WIDTH-1:0]  misr_next,
  output logic                  complete
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [SIG_WIDTH-1:0] misr;
  logic [SIG_WIDTH-1:0] fold;
  logic [MAX_BUS-1:0]   bus_ext;
  logic [CNT_W-1:0]     cnt;
  logic                 fb;

  assign bus_ext   = MAX_BUS'(data_in);
  assign fold      = fold_bus(bus_ext);
  assign fb        = ^(misr & SIG_TAPS);
  assign misr_next = {misr[SIG_WIDTH-2:0], fb} ^ fold;
  assign complete  = data_valid && (cnt == CNT_W'(WINDOW - 1));

  // The final word is absorbed into misr_next; the register restarts from the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      misr <= SIG_SEED;
      cnt  <= '0;
    end else if (data_valid) begin
      if (complete) begin
        misr <= SIG_SEED;
        cnt  <= '0;
      end else begin
        misr <= misr_next;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_signature_compactor.sv
// Compacts a wide bus into 32-bit signatures and shifts each out MSB first; SIG_PARITY_EN appends even parity.
// First frame bit one cycle after completion, sig_done FRAME_LEN cycles after; no backpressure.
module output_signature_compactor
  import sig_compactor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  output_signature_compactor_if.slave   bus
);

  generate
    if (WINDOW < FRAME_LEN) begin : g_window_chk
      $error("WINDOW (%0d) must be >= FRAME_LEN (%0d)", WINDOW, FRAME_LEN);
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_BUS) begin : g_width_chk
      $error("DATA_WIDTH (%0d) must be in 1..%0d", DATA_WIDTH, MAX_BUS);
    end
  endgenerate

  logic [SIG_WIDTH-1:0] misr_next;
  logic                 complete;

  misr_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .WINDOW     (WINDOW)
  ) u_misr (
    .clk        (clk),
    .reset      (reset),
    .data_in    (bus.data_in),
    .data_valid (bus.data_valid),
    .misr_next  (misr_next),
    .complete   (complete)
  );

  sig_state_t           state, state_nxt;
  logic [SIG_WIDTH-1:0] shreg;
  logic [5:0]           bit_idx;
  logic                 last_bit;
  logic                 out_bit, frame_bit, done_bit;

  assign last_bit = (bit_idx == 6'(FRAME_LEN - 1));

`ifdef SIG_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (reset) begin
      par <= 1'b0;
    end else if (complete) begin
      par <= ^misr_next;
    end
  end
`endif

  // A completion on the last frame bit reloads the shifter, giving gap-free frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_nxt;
      if (complete) begin
        shreg   <= misr_next;
        bit_idx <= '0;
      end else if (state == SHIFT) begin
        shreg   <= {shreg[SIG_WIDTH-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    frame_bit = 1'b0;
    out_bit   = 1'b0;
    done_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (complete) state_nxt = SHIFT;
      end
      SHIFT: begin
        frame_bit = 1'b1;
        out_bit   = shreg[SIG_WIDTH-1];
`ifdef SIG_PARITY_EN
        if (bit_idx == 6'(SIG_WIDTH)) out_bit = par;
`endif
        if (last_bit) begin
          done_bit  = 1'b1;
          state_nxt = complete ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sig_out   = out_bit;
  assign bus.sig_frame = frame_bit;
  assign bus.sig_done  = done_bit;

endmodule
